s_axi4l_rd_channel: RTL and testbench
=====================================

// Module: s_axi4l_rd_channel
//
// PURPOSE
//  AXI4-Lite slave read channel: the read-side counterpart of s_axi4l_wr_channel.
//  - Accepts one AR transaction at a time and decodes the word index.
//  - Issues a single-cycle read request to the register file and waits for its data.
//  - Returns RDATA/RRESP on the R channel.
//  - Sits between the AXI interconnect and the shared register file, beside the write channel.
//
// PARAMETERS
//  ADDR_WIDTH  32  AXI byte-address width
//  DATA_WIDTH  32  RDATA / register width (only 32 supported)
//  NUM_REGS    16  decoded registers; word index >= NUM_REGS -> SLVERR
//
// PORTS
//  i_axi_clock         in   1           single clock, all logic rising-edge
//  i_axi_aresetn       in   1           reset, asynchronous assert, active-low
//  i_axi_araddr        in   ADDR_WIDTH  read byte address
//  i_axi_arprot        in   3           protection bits; captured, functionally ignored
//  i_axi_araddr_valid  in   1           ARVALID
//  o_axi_araddr_ready  out  1           ARREADY
//  o_axi_rdata         out  DATA_WIDTH  RDATA
//  o_axi_rresp         out  2           RRESP (OKAY=2'b00, SLVERR=2'b10)
//  o_axi_rdata_valid   out  1           RVALID
//  i_axi_rdata_ready   in   1           RREADY
//  o_raddr             out  ADDR_WIDTH  captured byte address to register file
//  o_rreq              out  1           one-cycle read strobe to register file
//  i_rdata             in   DATA_WIDTH  register file read data
//  i_rdata_valid       in   1           i_rdata valid; may coincide with o_rreq or come later
//
// BEHAVIOUR
//  Reset values (while i_axi_aresetn=0):
//   - o_axi_araddr_ready=0, o_axi_rdata_valid=0, o_rreq=0
//   - o_axi_rdata=0, o_axi_rresp=OKAY, o_raddr=0, state=IDLE
//   - ARREADY rises on the first clock edge after reset deasserts.
//  All outputs are registered. FSM:
//   - IDLE: ARREADY=1. On ARVALID&ARREADY:
//     - capture araddr/arprot; ARREADY->0.
//     - idx = araddr[ADDR_WIDTH-1:2]; araddr[1:0] ignored.
//     - idx < NUM_REGS  -> REQ, o_rreq=1 next cycle.
//     - idx >= NUM_REGS -> RESP: RDATA=0, RRESP=SLVERR, no rreq.
//   - REQ: o_rreq high exactly this one cycle, o_raddr valid.
//     - i_rdata_valid=1 this cycle -> RESP (latch i_rdata, RRESP=OKAY).
//     - otherwise -> WAIT.
//   - WAIT: hold until i_rdata_valid; latch i_rdata, RRESP=OKAY -> RESP.
//     - No timeout: an unresponsive register file stalls the channel.
//   - RESP: RVALID=1; RDATA/RRESP held stable until RREADY.
//     - On RVALID&RREADY: RVALID->0, ARREADY->1 next cycle (IDLE).
//  Latency from AR handshake at cycle N:
//   - in-range, zero-wait register file -> RVALID at N+2.
//   - out-of-range -> RVALID at N+1.
//   - RREADY already high when RVALID rises -> completes that cycle.
//   - Max throughput: one read per 3 cycles (ARREADY re-asserts the cycle after the R handshake).
//  Boundaries:
//   - ARVALID while busy is ignored (ARREADY=0); the master must hold it.
//   - i_rdata_valid outside REQ/WAIT is ignored.
//   - RREADY while RVALID=0 has no effect.
//   - RVALID never deasserts before its handshake.
//   - Reset mid-transaction drops it; outputs return to reset values asynchronously.
//   - idx comparison is unsigned over the full upper address field (no aliasing).
//
// STRUCTURE
//  - Shared package axi4l_pkg: RESP_OKAY, RESP_SLVERR, rd_state_t enum {IDLE, REQ, WAIT, RESP}.
//    The write channel uses the same RESP constants.
//  - No sub-module: decode and FSM sit in one always_ff plus a small comb block.
//
// TESTING
//  1. Reset: hold aresetn=0 5 cycles -> ARREADY=0, RVALID=0, rreq=0; ARREADY=1 one cycle after release.
//  2. Read 0x8, reg[2]=0xDEADBEEF, zero-wait, RREADY=1
//     -> rreq at N+1 with raddr=0x8; RVALID at N+2; RDATA=0xDEADBEEF, RRESP=00.
//  3. Read 0x40 with NUM_REGS=16 -> no rreq; RVALID at N+1; RDATA=0, RRESP=2'b10.
//  4. Register file delays i_rdata_valid 3 cycles; RREADY low 4 cycles after RVALID
//     -> RVALID/RDATA stable throughout; exactly one rreq.
//  5. Back-to-back reads 0x0, 0x4 with ARVALID held high
//     -> second AR accepted only after first R handshake; correct data order.
//  6. Assert aresetn=0 in WAIT -> immediate reset values; next read of 0xC returns reg[3] with OKAY.

Source files
------------

// File: rtl/axi4l_pkg.sv
// rtl/axi4l_pkg.sv - shared AXI4-Lite response codes and read-channel FSM states
package axi4l_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT,
      RESP
   } rd_state_t;

endpackage

// File: rtl/s_axi4l_rd_channel.sv
// rtl/s_axi4l_rd_channel.sv - AXI4-Lite slave read channel in front of the shared register file
module s_axi4l_rd_channel
   import axi4l_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REGS   = 16
) (
   input  logic                  i_axi_clock,
   input  logic                  i_axi_aresetn,
   input  logic [ADDR_WIDTH-1:0] i_axi_araddr,
   input  logic [2:0]            i_axi_arprot,
   input  logic                  i_axi_araddr_valid,
   output logic                  o_axi_araddr_ready,
   output logic [DATA_WIDTH-1:0] o_axi_rdata,
   output logic [1:0]            o_axi_rresp,
   output logic                  o_axi_rdata_valid,
   input  logic                  i_axi_rdata_ready,
   output logic [ADDR_WIDTH-1:0] o_raddr,
   output logic                  o_rreq,
   input  logic [DATA_WIDTH-1:0] i_rdata,
   input  logic                  i_rdata_valid
);

   localparam logic [ADDR_WIDTH-1:0] NUM_REGS_W = ADDR_WIDTH'(NUM_REGS);

   rd_state_t             state_q, state_d;
   logic                  arready_q, arready_d;
   logic                  rvalid_q, rvalid_d;
   logic                  rreq_q, rreq_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic [1:0]            rresp_q, rresp_d;
   logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
   logic [2:0]            arprot_q, arprot_d;

   logic ar_hs;
   logic in_range;
   logic rd_capture;
   logic unused_arprot;

   // Full upper field is compared so high address bits never alias onto a register.
   assign in_range   = {2'b00, i_axi_araddr[ADDR_WIDTH-1:2]} < NUM_REGS_W;
   assign ar_hs      = (state_q == IDLE) && i_axi_araddr_valid && arready_q;
   assign rd_capture = ((state_q == REQ) || (state_q == WAIT)) && i_rdata_valid;

   assign unused_arprot = ^arprot_q;

   always_ff @(posedge i_axi_clock or negedge i_axi_aresetn) begin
      if (!i_axi_aresetn) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (ar_hs) begin
               state_d = in_range ? REQ : RESP;
            end
         end
         REQ: begin
            state_d = i_rdata_valid ? RESP : WAIT;
         end
         WAIT: begin
            if (i_rdata_valid) begin
               state_d = RESP;
            end
         end
         RESP: begin
            if (rvalid_q && i_axi_rdata_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Handshake outputs follow the next state so every output comes straight from a flop.
   always_comb begin
      raddr_d   = raddr_q;
      arprot_d  = arprot_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      arready_d = (state_d == IDLE);
      rreq_d    = (state_d == REQ);
      rvalid_d  = (state_d == RESP);

      if (ar_hs) begin
         raddr_d  = i_axi_araddr;
         arprot_d = i_axi_arprot;
         if (!in_range) begin
            rdata_d = '0;
            rresp_d = RESP_SLVERR;
         end
      end

      if (rd_capture) begin
         rdata_d = i_rdata;
         rresp_d = RESP_OKAY;
      end
   end

   always_ff @(posedge i_axi_clock or negedge i_axi_aresetn) begin
      if (!i_axi_aresetn) begin
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rreq_q    <= 1'b0;
         rdata_q   <= '0;
         rresp_q   <= RESP_OKAY;
         raddr_q   <= '0;
         arprot_q  <= '0;
      end else begin
         arready_q <= arready_d;
         rvalid_q  <= rvalid_d;
         rreq_q    <= rreq_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
         raddr_q   <= raddr_d;
         arprot_q  <= arprot_d;
      end
   end

   assign o_axi_araddr_ready = arready_q;
   assign o_axi_rdata_valid  = rvalid_q;
   assign o_axi_rdata        = rdata_q;
   assign o_axi_rresp        = rresp_q;
   assign o_raddr            = raddr_q;
   assign o_rreq             = rreq_q;

endmodule

// File: tb/tb_s_axi4l_rd_channel.sv
// tb/tb_s_axi4l_rd_channel.sv - directed self-checking bench for the AXI4-Lite read channel
module tb_s_axi4l_rd_channel;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] araddr;
   logic [2:0]  arprot;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;
   logic [31:0] raddr;
   logic        rreq;
   logic [31:0] rf_data;
   logic        rf_valid;

   int checks = 0;
   int errors = 0;
   int rf_delay = 0;
   int rf_cnt = 0;
   logic rf_pending = 1'b0;
   int rreq_count = 0;
   logic [31:0] regs [16];

   always #5 clk = ~clk;

   s_axi4l_rd_channel #(
      .ADDR_WIDTH(32),
      .DATA_WIDTH(32),
      .NUM_REGS  (16)
   ) dut (
      .i_axi_clock       (clk),
      .i_axi_aresetn     (rst_n),
      .i_axi_araddr      (araddr),
      .i_axi_arprot      (arprot),
      .i_axi_araddr_valid(arvalid),
      .o_axi_araddr_ready(arready),
      .o_axi_rdata       (rdata),
      .o_axi_rresp       (rresp),
      .o_axi_rdata_valid (rvalid),
      .i_axi_rdata_ready (rready),
      .o_raddr           (raddr),
      .o_rreq            (rreq),
      .i_rdata           (rf_data),
      .i_rdata_valid     (rf_valid)
   );

   // Register file model: answers rf_delay cycles after the strobe (0 = same cycle).
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rf_pending <= 1'b0;
         rf_cnt     <= 0;
      end else if (rreq && rf_delay != 0) begin
         rf_pending <= 1'b1;
         rf_cnt     <= 1;
      end else if (rf_pending) begin
         if (rf_cnt == rf_delay) rf_pending <= 1'b0;
         else rf_cnt <= rf_cnt + 1;
      end
   end

   always @(posedge clk) begin
      if (rreq) rreq_count <= rreq_count + 1;
   end

   assign rf_valid = (rf_delay == 0) ? rreq : (rf_pending && rf_cnt == rf_delay);
   assign rf_data  = rf_valid ? regs[raddr[5:2]] : 32'h0BAD_0BAD;

   task automatic test_reset();
      rst_n = 1'b0; arvalid = 1'b0; rready = 1'b0; araddr = '0; arprot = '0;
      repeat (5) @(negedge clk);
      checks++; if (arready !== 1'b0) begin errors++; $display("FAIL reset_arready: got %b expected 0", arready); end
      checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b expected 0", rvalid); end
      checks++; if (rreq !== 1'b0) begin errors++; $display("FAIL reset_rreq: got %b expected 0", rreq); end
      checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
      checks++; if (rresp !== 2'b00) begin errors++; $display("FAIL reset_rresp: got %b expected 00", rresp); end
      checks++; if (raddr !== 32'h0) begin errors++; $display("FAIL reset_raddr: got %h expected 0", raddr); end
      rst_n = 1'b1;
      #1;
      checks++; if (arready !== 1'b0) begin errors++; $display("FAIL release_arready_early: got %b expected 0", arready); end
      @(negedge clk);
      checks++; if (arready !== 1'b1) begin errors++; $display("FAIL release_arready: got %b expected 1", arready); end
   endtask

   task automatic test_in_range();
      int base;
      base = rreq_count;
      araddr = 32'h8; arprot = 3'b101; arvalid = 1'b1; rready = 1'b1;
      checks++; if (arready !== 1'b1) begin errors++; $display("FAIL inr_arready: got %b expected 1", arready); end
      @(negedge clk);
      arvalid = 1'b0;
      checks++; if (rreq !== 1'b1) begin errors++; $display("FAIL inr_rreq: got %b expected 1", rreq); end
      checks++; if (raddr !== 32'h8) begin errors++; $display("FAIL inr_raddr: got %h expected 00000008", raddr); end
      checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL inr_rvalid_early: got %b expected 0", rvalid); end
      checks++; if (arready !== 1'b0) begin errors++; $display("FAIL inr_arready_busy: got %b expected 0", arready); end
      @(negedge clk);
      checks++; if (rvalid !== 1'b1) begin errors++; $display("FAIL inr_rvalid: got %b expected 1", rvalid); end
      checks++; if (rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL inr_rdata: got %h expected deadbeef", rdata); end
      checks++; if (rresp !== 2'b00) begin errors++; $display("FAIL inr_rresp: got %b expected 00", rresp); end
      checks++; if (rreq !== 1'b0) begin errors++; $display("FAIL inr_rreq_pulse: got %b expected 0", rreq); end
      @(negedge clk);
      checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL inr_rvalid_done: got %b expected 0", rvalid); end
      checks++; if (arready !== 1'b1) begin errors++; $display("FAIL inr_arready_again: got %b expected 1", arready); end
      checks++; if (rreq_count - base !== 1) begin errors++; $display("FAIL inr_rreq_count: got %0d expected 1", rreq_count - base); end
   endtask

   task automatic test_out_of_range();
      logic [31:0] addrs [2];
      int base;
      addrs[0] = 32'h40;
      addrs[1] = 32'h1000_0008;
      for (int k = 0; k < 2; k++) begin
         base = rreq_count;
         araddr = addrs[k]; arvalid = 1'b1; rready = 1'b1;
         @(negedge clk);
         arvalid = 1'b0;
         checks++; if (rvalid !== 1'b1) begin errors++; $display("FAIL oor_rvalid[%0d]: got %b expected 1", k, rvalid); end
         checks++; if (rresp !== 2'b10) begin errors++; $display("FAIL oor_rresp[%0d]: got %b expected 10", k, rresp); end
         checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL oor_rdata[%0d]: got %h expected 0", k, rdata); end
         checks++; if (rreq !== 1'b0) begin errors++; $display("FAIL oor_rreq[%0d]: got %b expected 0", k, rreq); end
         @(negedge clk);
         checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL oor_rvalid_done[%0d]: got %b expected 0", k, rvalid); end
         checks++; if (arready !== 1'b1) begin errors++; $display("FAIL oor_arready[%0d]: got %b expected 1", k, arready); end
         checks++; if (rreq_count !== base) begin errors++; $display("FAIL oor_rreq_count[%0d]: got %0d expected %0d", k, rreq_count, base); end
      end
   endtask

   task automatic test_wait_stall();
      int base;
      int n;
      base = rreq_count;
      rf_delay = 3;
      araddr = 32'h14; arvalid = 1'b1; rready = 1'b0;
      @(negedge clk);
      arvalid = 1'b0;
      checks++; if (rreq !== 1'b1) begin errors++; $display("FAIL stall_rreq: got %b expected 1", rreq); end
      n = 0;
      while (rvalid !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++; if (n !== 4) begin errors++; $display("FAIL stall_latency: got %0d cycles expected 4", n); end
      for (int c = 0; c < 4; c++) begin
         checks++; if (rvalid !== 1'b1) begin errors++; $display("FAIL stall_rvalid[%0d]: got %b expected 1", c, rvalid); end
         checks++; if (rdata !== 32'hA5A5_0005) begin errors++; $display("FAIL stall_rdata[%0d]: got %h expected a5a50005", c, rdata); end
         @(negedge clk);
      end
      rready = 1'b1;
      @(negedge clk);
      checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL stall_rvalid_done: got %b expected 0", rvalid); end
      checks++; if (rreq_count - base !== 1) begin errors++; $display("FAIL stall_rreq_count: got %0d expected 1", rreq_count - base); end
      rf_delay = 0;
   endtask

   task automatic test_back_to_back();
      araddr = 32'h0; arvalid = 1'b1; rready = 1'b1;
      @(negedge clk);
      araddr = 32'h4;
      checks++; if (arready !== 1'b0) begin errors++; $display("FAIL b2b_arready_busy: got %b expected 0", arready); end
      checks++; if (raddr !== 32'h0) begin errors++; $display("FAIL b2b_raddr0: got %h expected 0", raddr); end
      @(negedge clk);
      checks++; if (rvalid !== 1'b1) begin errors++; $display("FAIL b2b_rvalid0: got %b expected 1", rvalid); end
      checks++; if (rdata !== 32'hA5A5_0000) begin errors++; $display("FAIL b2b_rdata0: got %h expected a5a50000", rdata); end
      checks++; if (arready !== 1'b0) begin errors++; $display("FAIL b2b_arready_resp: got %b expected 0", arready); end
      @(negedge clk);
      checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL b2b_rvalid_gap: got %b expected 0", rvalid); end
      checks++; if (arready !== 1'b1) begin errors++; $display("FAIL b2b_arready_idle: got %b expected 1", arready); end
      @(negedge clk);
      arvalid = 1'b0;
      checks++; if (rreq !== 1'b1) begin errors++; $display("FAIL b2b_rreq1: got %b expected 1", rreq); end
      checks++; if (raddr !== 32'h4) begin errors++; $display("FAIL b2b_raddr1: got %h expected 00000004", raddr); end
      @(negedge clk);
      checks++; if (rvalid !== 1'b1) begin errors++; $display("FAIL b2b_rvalid1: got %b expected 1", rvalid); end
      checks++; if (rdata !== 32'hA5A5_0001) begin errors++; $display("FAIL b2b_rdata1: got %h expected a5a50001", rdata); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      rf_delay = 10;
      araddr = 32'h20; arvalid = 1'b1; rready = 1'b1;
      @(negedge clk);
      arvalid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++; if (arready !== 1'b0) begin errors++; $display("FAIL mid_arready: got %b expected 0", arready); end
      checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL mid_rvalid: got %b expected 0", rvalid); end
      checks++; if (rreq !== 1'b0) begin errors++; $display("FAIL mid_rreq: got %b expected 0", rreq); end
      checks++; if (raddr !== 32'h0) begin errors++; $display("FAIL mid_raddr: got %h expected 0", raddr); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      rf_delay = 0;
      @(negedge clk);
      checks++; if (arready !== 1'b1) begin errors++; $display("FAIL mid_arready_release: got %b expected 1", arready); end
      araddr = 32'hC; arvalid = 1'b1;
      @(negedge clk);
      arvalid = 1'b0;
      @(negedge clk);
      checks++; if (rvalid !== 1'b1) begin errors++; $display("FAIL mid_rvalid3: got %b expected 1", rvalid); end
      checks++; if (rdata !== 32'hA5A5_0003) begin errors++; $display("FAIL mid_rdata3: got %h expected a5a50003", rdata); end
      checks++; if (rresp !== 2'b00) begin errors++; $display("FAIL mid_rresp3: got %b expected 00", rresp); end
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 16; i++) regs[i] = 32'hA5A5_0000 | 32'(i);
      regs[2] = 32'hDEADBEEF;
      test_reset();
      test_in_range();
      test_out_of_range();
      test_wait_stall();
      test_back_to_back();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
